// File: rtl/bcd_convert_ctrl.sv
// Sequential 8-bit binary to 3-digit BCD converter (shift-and-add-3).
// One iteration per clock; 8 iterations, then a single DONE cycle.
module bcd_convert_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] bin,
    output logic       busy,
    output logic       done,
    output logic [3:0] bcd100,
    output logic [3:0] bcd10,
    output logic [3:0] bcd1
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  bin_q, bin_d;          // operand being shifted out MSB first
    logic [11:0] scratch_q, scratch_d;  // BCD digits being built
    logic [2:0]  cnt_q, cnt_d;          // iteration counter, 7 marks the last one
    logic [11:0] res_q, res_d;          // held result {hundreds, tens, units}
    logic [11:0] adj;                   // scratch after the add-3 correction

    function automatic logic [3:0] add3(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

    // Correct every digit >= 5 before the shift so it carries into the next digit.
    always_comb begin
        adj = {add3(scratch_q[11:8]), add3(scratch_q[7:4]), add3(scratch_q[3:0])};
    end

    // Next-state and datapath: accept in IDLE/DONE, iterate in SHIFT.
    always_comb begin
        state_d   = state_q;
        bin_d     = bin_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        res_d     = res_q;
        case (state_q)
            IDLE, DONE: begin
                // DONE accepts a new start too, giving back-to-back conversions.
                if (start) begin
                    state_d   = SHIFT;
                    bin_d     = bin;
                    scratch_d = '0;
                    cnt_d     = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                // Hundreds digit is at most 1 before the last shift, so adj[11] is always 0.
                scratch_d = {adj[10:0], bin_q[7]};
                bin_d     = {bin_q[6:0], 1'b0};
                cnt_d     = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    state_d = DONE;
                    res_d   = {adj[10:0], bin_q[7]};
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any conversion in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            bin_q     <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            res_q     <= '0;
        end else begin
            state_q   <= state_d;
            bin_q     <= bin_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            res_q     <= res_d;
        end
    end

    // Status flags decode straight from state, so reset clears them immediately.
    always_comb begin
        busy   = (state_q == SHIFT);
        done   = (state_q == DONE);
        bcd100 = res_q[11:8];
        bcd10  = res_q[7:4];
        bcd1   = res_q[3:0];
    end

endmodule

// File: tb/tb_bcd_convert_ctrl.sv
// Directed bench for bcd_convert_ctrl: latency, known values, sweep,
// start-while-busy, held start, and mid-conversion reset.
module tb_bcd_convert_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] bin;
    logic       busy;
    logic       done;
    logic [3:0] bcd100, bcd10, bcd1;

    int n_chk  = 0;
    int n_fail = 0;
    logic [11:0] last_res = 12'h000;

    bcd_convert_ctrl dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .bin    (bin),
        .busy   (busy),
        .done   (done),
        .bcd100 (bcd100),
        .bcd10  (bcd10),
        .bcd1   (bcd1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Start one conversion with a 1-cycle start pulse and check its timing and result.
    task automatic convert(input logic [7:0] v, input logic [11:0] exp_res, input string tag);
        int cyc;
        @(negedge clk);
        start = 1'b1;
        bin   = v;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        bin   = 8'hxx;
        cyc   = 0;
        while (busy && cyc < 20) begin
            cyc++;
            if (cyc == 4) chk({tag, "_hold"}, {4'h0, bcd100, bcd10, bcd1}, {4'h0, last_res});
            @(negedge clk);
        end
        chk({tag, "_busy_cycles"}, 16'(cyc), 16'd8);
        chk({tag, "_done"}, {15'd0, done}, 16'd1);
        chk({tag, "_result"}, {4'h0, bcd100, bcd10, bcd1}, {4'h0, exp_res});
        @(negedge clk);
        chk({tag, "_after"}, {14'd0, busy, done}, 16'd0);
        last_res = exp_res;
    endtask

    initial begin
        int dcount;
        logic [11:0] e;
        rst_n = 1'b0;
        start = 1'b0;
        bin   = 8'h00;

        // Reset state
        #12;
        chk("reset_flags", {14'd0, busy, done}, 16'd0);
        chk("reset_outs", {4'h0, bcd100, bcd10, bcd1}, 16'h000);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_flags", {14'd0, busy, done}, 16'd0);

        // Known values
        convert(8'd0,   12'h000, "bin0");
        convert(8'd255, 12'h255, "bin255");
        convert(8'd99,  12'h099, "bin99");
        convert(8'd100, 12'h100, "bin100");
        convert(8'd10,  12'h010, "bin10");

        // Exhaustive sweep against decimal arithmetic
        for (int i = 0; i < 256; i++) begin
            e = {4'(i / 100), 4'((i / 10) % 10), 4'(i % 10)};
            convert(8'(i), e, "sweep");
        end

        // start and bin changes while busy are ignored
        @(negedge clk);
        start = 1'b1;
        bin   = 8'd42;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        bin   = 8'd0;
        @(negedge clk);
        @(negedge clk);
        start = 1'b1;
        bin   = 8'd200;
        @(negedge clk);
        start = 1'b0;
        dcount = 0;
        for (int i = 0; i < 20; i++) begin
            if (done) begin
                dcount++;
                if (dcount == 1) chk("busy_ign_result", {4'h0, bcd100, bcd10, bcd1}, 16'h042);
            end
            @(negedge clk);
        end
        chk("busy_ign_done_count", 16'(dcount), 16'd1);
        chk("busy_ign_idle", {14'd0, busy, done}, 16'd0);

        // start held high: done every 9th cycle, busy otherwise
        @(negedge clk);
        start = 1'b1;
        bin   = 8'd123;
        @(posedge clk);
        for (int i = 0; i < 27; i++) begin
            @(negedge clk);
            chk("held_flags", {14'd0, busy, done}, (i % 9 == 8) ? 16'd1 : 16'd2);
            if (i % 9 == 8) chk("held_result", {4'h0, bcd100, bcd10, bcd1}, 16'h123);
        end
        start = 1'b0;
        @(negedge clk);
        chk("held_stop", {14'd0, busy, done}, 16'd0);

        // Reset in the middle of a conversion aborts it
        @(negedge clk);
        start = 1'b1;
        bin   = 8'd77;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort_busy_before", {15'd0, busy}, 16'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_flags", {14'd0, busy, done}, 16'd0);
        chk("abort_outs", {4'h0, bcd100, bcd10, bcd1}, 16'h000);
        @(negedge clk);
        rst_n = 1'b1;
        dcount = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done || busy) dcount++;
        end
        chk("abort_no_activity", 16'(dcount), 16'd0);
        last_res = 12'h000;
        convert(8'd77, 12'h077, "after_abort");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Safety timeout
    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
